ram_arbiter: RTL
================

# ram_arbiter

Parametrised N-port arbiter placing several ibex-style request/grant/rvalid memory masters onto one single-port RAM with fixed one-cycle read latency. It generalises the two-way fixed-priority instruction/data mux to N ports, and selects fixed-priority or round-robin arbitration by parameter. Out-of-window accesses get an error response. Responses route back to the originating port. It sits between the core and testbench masters and `ram_1p`.

## Interface
- `N_PORTS`, 2: number of requesting masters (2..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8`.
- `MEM_START`, 32'h0: window base, aligned to `MEM_SIZE`.
- `MEM_SIZE`, 65536: window size in bytes, power of two.
- `ARB_MODE`, `ARB_FIXED`: `ARB_FIXED` (lowest index wins) or `ARB_RR` (round-robin).
- `CNT_W`, 16: width of each statistics counter.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `port_req_i` in N_PORTS: request per port.
- `port_we_i` in N_PORTS: write enable per port.
- `port_be_i` in N_PORTS*DATA_W/8: byte enables, port i in slice i.
- `port_addr_i` in N_PORTS*ADDR_W: byte addresses.
- `port_wdata_i` in N_PORTS*DATA_W: write data.
- `port_gnt_o` out N_PORTS: grant, one-hot or zero.
- `port_rvalid_o` out N_PORTS: response valid, one-hot or zero.
- `port_err_o` out N_PORTS: error flag, qualified by rvalid.
- `port_rdata_o` out DATA_W: read data, shared by all ports and qualified by rvalid.
- `ram_req_o` out 1: RAM access strobe.
- `ram_we_o` out 1: RAM write.
- `ram_be_o` out DATA_W/8: RAM byte enables.
- `ram_addr_o` out ADDR_W: RAM byte address, passed through unmasked.
- `ram_wdata_o` out DATA_W: RAM write data.
- `ram_rdata_i` in DATA_W: RAM read data, valid the cycle after `ram_req_o`.
- `grant_cnt_o` out N_PORTS*CNT_W: per-port grant counters; present only with `RAM_ARB_STATS_EN`.

## Operation
- Each cycle, at most one requesting port wins.
- **Fixed mode:** the lowest index wins. Port 0 is the instruction fetch port.
- **Round-robin mode:**
  - The pointer `last` holds the index of the most recent winner.
  - The search starts at `last+1` and wraps from N_PORTS-1 to 0.
  - `last` updates only on a grant.
- **In-window winner** (`(addr & ~(MEM_SIZE-1)) == MEM_START`):
  - `port_gnt_o[i]=1` and `ram_req_o=1`.
  - `ram_we_o`, `ram_be_o`, `ram_addr_o` and `ram_wdata_o` take port i's fields.
- **Out-of-window winner:**
  - `port_gnt_o[i]=1` and `ram_req_o=0`.
  - A response with error is queued.
- **Idle:** all `ram_*` outputs are 0.
- **Response stage:** registers `resp_valid`, `resp_port` and `resp_err`, loaded on every grant.
  - The next cycle drives `port_rvalid_o[resp_port]=1` and `port_err_o[resp_port]=resp_err`.
  - `port_rdata_o = ram_rdata_i`, or 0 when `resp_err=1`.
- Writes also receive an rvalid, with `rdata` as don't-care.
- A port keeping `req` high after its grant is a new request.
- **Reset:** `rst_i` clears `resp_valid` and `resp_err`, and sets `last = N_PORTS-1` so port 0 wins first. A pending response is dropped.
- **Outputs during reset:** all gnt, rvalid, err and `ram_req_o` outputs are 0, rdata is 0, and counters are 0.

## Timing
- Grant is combinational from `req`, in the same cycle.
- The response arrives exactly 1 cycle after grant.
- Back-to-back grants are allowed, one per cycle, giving full RAM throughput.
- No combinational path exists from `ram_rdata_i` to any gnt output.
- Requests from several ports in the same cycle are resolved by the arbitration rule. Losers see `gnt=0` and must hold their request.
- Grant and response to different ports may occur in the same cycle.
- A grant and a response may also coincide on the same port.
- `last` updates on the clock edge after the grant.

## Configuration
- `RAM_ARB_STATS_EN` defined:
  - `grant_cnt_o` exists.
  - The counter for port i increments on each `port_gnt_o[i]`, including out-of-window grants.
  - Counters saturate at all-ones and clear on `rst_i`.
- Undefined: the port and the counters are absent. Arbitration behaviour is identical either way.

## Structure
- `ram_arb_pkg` holds:
  - `arb_mode_e` {ARB_FIXED, ARB_RR};
  - the `MAX_PORTS=8` constant;
  - the `resp_t` struct {valid, port index, err}.
- Sub-module `ram_arb_pick` is a combinational rotating-priority picker with inputs `req` and `start` and outputs `gnt_onehot` and `idx`.
  - Fixed mode ties `start` to 0.

## Test plan
- Fixed priority, N_PORTS=2, both ports requesting reads of 0x100 and 0x200 (both in window) for 4 cycles -> port 0 is granted every cycle, port 1 never, and port 0's rvalid follows each grant by 1 cycle.
- Round-robin, N_PORTS=4, all ports requesting constantly -> grant order 0,1,2,3,0,1.
- Round-robin, after port 2 wins, only ports 1 and 3 requesting -> 3 is granted next, then 1.
- Write 0xDEADBEEF with be=4'b0011 to 0x40 via port 1, then read 0x40 via port 0 -> rdata 0x0000BEEF on `port_rvalid_o[0]`, and err=0 on both responses.
- Port 1 reads 0x0001_0000 with MEM_SIZE=64 kB -> gnt with `ram_req_o=0`, then rvalid and err=1 with rdata 0 next cycle.
- Assert `rst_i` in the cycle after a grant -> no rvalid is seen. After reset the first contention goes to port 0. With stats enabled and CNT_W=4, 20 grants to port 0 read back as 4'hF.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the N-port RAM arbiter.
//   arb_mode_e  - arbitration policy (fixed priority or round-robin)
//   MAX_PORTS   - upper bound on the number of requesting masters
//   port_idx_t  - port index wide enough for MAX_PORTS
//   resp_t      - registered response stage {valid, port, err}
package ram_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned MAX_PORTS = 8;
  localparam int unsigned IDX_W     = $clog2(MAX_PORTS);

  typedef logic [IDX_W-1:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t port;
    logic      err;
  } resp_t;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational rotating-priority picker.
//   req        in  N : request vector
//   start      in    : index given highest priority this cycle (must be < N)
//   gnt_onehot out N : one-hot winner, zero when nothing requests
//   idx        out   : index of the winner (0 when nothing requests)
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  port_idx_t    start,
  output logic [N-1:0] gnt_onehot,
  output port_idx_t    idx
);

  logic [N-1:0] rot;
  logic         found;
  int unsigned  off;
  int unsigned  win;

  always_comb begin
    // Rotate so that 'start' lands at bit 0; the lowest set bit of the
    // rotated vector is then the winner's distance from 'start'.
    rot   = N'({req, req} >> start);
    found = |rot;
    off   = 0;
    for (int unsigned j = N; j > 0; j--) begin
      if (rot[j-1]) off = j - 1;
    end
    win = (32'(start) + off) % N;
    gnt_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_onehot[i] = found && (win == i);
    end
    idx = found ? port_idx_t'(win) : '0;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: places N request/grant/rvalid memory masters onto one
// single-port RAM with one-cycle read latency.
//   Parameters: N_PORTS (2..8), ADDR_W, DATA_W, MEM_START, MEM_SIZE,
//               ARB_MODE (ARB_FIXED | ARB_RR), CNT_W.
//   clk_i, rst_i (synchronous, active-high)
//   port_req_i/we_i/be_i/addr_i/wdata_i : packed per-port request fields
//   port_gnt_o   : same-cycle grant, one-hot or zero
//   port_rvalid_o/port_err_o : response one cycle after grant
//   port_rdata_o : shared read data, qualified by rvalid
//   ram_*        : single-port RAM interface, all zero when idle
//   grant_cnt_o  : saturating per-port grant counters, only when
//                  RAM_ARB_STATS_EN is defined
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned         N_PORTS   = 2,
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         DATA_W    = 32,
  parameter logic [ADDR_W-1:0]   MEM_START = '0,
  parameter int unsigned         MEM_SIZE  = 65536,
  parameter arb_mode_e           ARB_MODE  = ARB_FIXED,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_PORTS-1:0]            port_req_i,
  input  logic [N_PORTS-1:0]            port_we_i,
  input  logic [N_PORTS*DATA_W/8-1:0]   port_be_i,
  input  logic [N_PORTS*ADDR_W-1:0]     port_addr_i,
  input  logic [N_PORTS*DATA_W-1:0]     port_wdata_i,
  output logic [N_PORTS-1:0]            port_gnt_o,
  output logic [N_PORTS-1:0]            port_rvalid_o,
  output logic [N_PORTS-1:0]            port_err_o,
  output logic [DATA_W-1:0]             port_rdata_o,
  output logic                          ram_req_o,
  output logic                          ram_we_o,
  output logic [DATA_W/8-1:0]           ram_be_o,
  output logic [ADDR_W-1:0]             ram_addr_o,
  output logic [DATA_W-1:0]             ram_wdata_o,
  input  logic [DATA_W-1:0]             ram_rdata_i
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [N_PORTS*CNT_W-1:0]      grant_cnt_o
`endif
);

  localparam int unsigned      BE_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WIN_MASK = ~(ADDR_W'(MEM_SIZE - 1));

  if (N_PORTS < 2 || N_PORTS > MAX_PORTS || CNT_W == 0) begin : g_param_check
    $error("ram_arbiter: unsupported parameter set");
  end

  logic [N_PORTS-1:0] req_eff;
  logic [N_PORTS-1:0] gnt;
  port_idx_t          gnt_idx;
  port_idx_t          start;
  port_idx_t          last_q;
  resp_t              resp_q;
  resp_t              resp_d;
  logic               any_gnt;
  logic               in_win;
  logic               win_we;
  logic [BE_W-1:0]    win_be;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  // Nothing is granted while reset is asserted.
  assign req_eff = rst_i ? '0 : port_req_i;

  // Round-robin searches from the port after the last winner, wrapping.
  assign start = (ARB_MODE == ARB_RR)
               ? ((last_q == port_idx_t'(N_PORTS - 1)) ? '0 : port_idx_t'(last_q + 1'b1))
               : '0;

  ram_arb_pick #(.N(N_PORTS)) u_pick (
    .req        (req_eff),
    .start      (start),
    .gnt_onehot (gnt),
    .idx        (gnt_idx)
  );

  assign any_gnt    = |gnt;
  assign port_gnt_o = gnt;

  always_comb begin
    win_we    = 1'b0;
    win_be    = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) begin
        win_we    = port_we_i[i];
        win_be    = port_be_i[i*BE_W +: BE_W];
        win_addr  = port_addr_i[i*ADDR_W +: ADDR_W];
        win_wdata = port_wdata_i[i*DATA_W +: DATA_W];
      end
    end
    in_win      = ((win_addr & WIN_MASK) == MEM_START);
    ram_req_o   = any_gnt && in_win;
    ram_we_o    = ram_req_o && win_we;
    ram_be_o    = ram_req_o ? win_be    : '0;
    ram_addr_o  = ram_req_o ? win_addr  : '0;
    ram_wdata_o = ram_req_o ? win_wdata : '0;
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = any_gnt;
    resp_d.port  = gnt_idx;
    resp_d.err   = any_gnt && !in_win;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q <= '0;
      last_q <= port_idx_t'(N_PORTS - 1);
    end else begin
      resp_q <= resp_d;
      if (any_gnt) last_q <= gnt_idx;
    end
  end

  // A response still held in resp_q while reset is asserted is suppressed.
  always_comb begin
    port_rvalid_o = '0;
    port_err_o    = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      port_rvalid_o[i] = resp_q.valid && !rst_i && (resp_q.port == port_idx_t'(i));
      port_err_o[i]    = resp_q.valid && !rst_i && resp_q.err && (resp_q.port == port_idx_t'(i));
    end
    port_rdata_o = (rst_i || resp_q.err) ? '0 : ram_rdata_i;
  end

`ifdef RAM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_PORTS];

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (rst_i) begin
        cnt_q[i] <= '0;
      end else if (gnt[i] && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      grant_cnt_o[i*CNT_W +: CNT_W] = rst_i ? '0 : cnt_q[i];
    end
  end
`endif

endmodule
